// File: rtl/sparhixcel_pkg.sv
// Shared SparHiXcel definitions: weight-load sequencer state encoding and the
// default widths that the SA controller and the weight-load sequencer agree on.
package sparhixcel_pkg;

  localparam int WLS_ADDR_WIDTH    = 16;
  localparam int WLS_N             = 3;
  localparam int WLS_NUM_COL_WIDTH = $clog2(WLS_N + 1);
  localparam int WLS_ROUND_WIDTH   = 4;

  typedef enum logic [2:0] {
    WLS_IDLE  = 3'd0,
    WLS_FETCH = 3'd1,
    WLS_LOAD  = 3'd2,
    WLS_READY = 3'd3,
    WLS_WAIT  = 3'd4,
    WLS_DONE  = 3'd5
  } wls_state_t;

endpackage

// File: rtl/weight_load_sequencer_if.sv
// Command, weight-memory and array-load signals of the weight-load sequencer.
// slave is the sequencer side, master the SA controller / memory / array side.
interface weight_load_sequencer_if
  import sparhixcel_pkg::*;
#(
  parameter int ADDR_WIDTH    = WLS_ADDR_WIDTH,
  parameter int NUM_COL_WIDTH = WLS_NUM_COL_WIDTH,
  parameter int ROUND_WIDTH   = WLS_ROUND_WIDTH
);

  logic                     start_i;
  logic [ADDR_WIDTH-1:0]    base_addr_i;
  logic [NUM_COL_WIDTH-1:0] filter_size_i;
  logic [ROUND_WIDTH-1:0]   n_rounds_i;
  logic                     weight_ready_i;
  logic                     array_busy_i;
  logic [ADDR_WIDTH-1:0]    weight_addr_o;
  logic                     rd_weight_ld_o;
  logic                     load_o;
  logic                     ready_o;
  logic                     busy_o;
  logic                     done_o;
  logic [ROUND_WIDTH-1:0]   round_o;

  modport slave (
    input  start_i, base_addr_i, filter_size_i, n_rounds_i,
           weight_ready_i, array_busy_i,
    output weight_addr_o, rd_weight_ld_o, load_o, ready_o,
           busy_o, done_o, round_o
  );

  modport master (
    output start_i, base_addr_i, filter_size_i, n_rounds_i,
           weight_ready_i, array_busy_i,
    input  weight_addr_o, rd_weight_ld_o, load_o, ready_o,
           busy_o, done_o, round_o
  );

endinterface

// File: rtl/weight_load_sequencer.sv
// Fetches filter_size weight words per round and pulses the array load per word.
// Define SPARHIXCEL_WLS_PREFETCH_EN to overlap the next fetch with the current load.
module weight_load_sequencer
  import sparhixcel_pkg::*;
#(
  parameter int ADDR_WIDTH    = WLS_ADDR_WIDTH,
  parameter int N             = WLS_N,
  parameter int NUM_COL_WIDTH = $clog2(N + 1),
  parameter int ROUND_WIDTH   = WLS_ROUND_WIDTH
) (
  input logic                    clk_i,
  input logic                    rd_weight_rst,
  weight_load_sequencer_if.slave bus
);

  localparam logic [NUM_COL_WIDTH-1:0] MAX_SIZE = NUM_COL_WIDTH'(N);

  wls_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]    last_q, last_d;
  logic [NUM_COL_WIDTH-1:0] size_q, size_d;
  logic [NUM_COL_WIDTH-1:0] word_q, word_d;
  logic [ROUND_WIDTH-1:0]   rounds_q, rounds_d;
  logic [ROUND_WIDTH-1:0]   round_q, round_d;

  logic                     strobe;
  logic                     loadPulse;
  logic                     readyPulse;
  logic                     donePulse;
  logic                     startLegal;
  logic [NUM_COL_WIDTH-1:0] wordNext;
  logic [ROUND_WIDTH-1:0]   roundNext;

  assign startLegal = (bus.filter_size_i != '0) && (bus.filter_size_i <= MAX_SIZE) &&
                      (bus.n_rounds_i != '0);
  assign wordNext   = word_q + NUM_COL_WIDTH'(1);
  assign roundNext  = round_q + ROUND_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    size_d     = size_q;
    word_d     = word_q;
    rounds_d   = rounds_q;
    round_d    = round_q;
    strobe     = 1'b0;
    loadPulse  = 1'b0;
    readyPulse = 1'b0;
    donePulse  = 1'b0;

    case (state_q)
      WLS_IDLE: begin
        if (bus.start_i && startLegal) begin
          size_d   = bus.filter_size_i;
          rounds_d = bus.n_rounds_i;
          addr_d   = bus.base_addr_i;
          word_d   = '0;
          round_d  = '0;
          state_d  = WLS_FETCH;
        end
      end
      WLS_FETCH: begin
        if (bus.weight_ready_i) begin
          strobe  = 1'b1;
          state_d = WLS_LOAD;
        end
      end
      WLS_LOAD: begin
        loadPulse = 1'b1;
        word_d    = wordNext;
        if (wordNext == size_q) begin
          state_d = WLS_READY;
        end else begin
`ifdef SPARHIXCEL_WLS_PREFETCH_EN
          // Overlap the next read with this load when memory accepts it.
          if (bus.weight_ready_i) begin
            strobe  = 1'b1;
            state_d = WLS_LOAD;
          end else begin
            state_d = WLS_FETCH;
          end
`else
          state_d = WLS_FETCH;
`endif
        end
      end
      WLS_READY: begin
        readyPulse = 1'b1;
        round_d    = roundNext;
        word_d     = '0;
        state_d    = (roundNext == rounds_q) ? WLS_DONE : WLS_WAIT;
      end
      WLS_WAIT: begin
        if (!bus.array_busy_i) begin
          state_d = WLS_FETCH;
        end
      end
      WLS_DONE: begin
        donePulse = 1'b1;
        state_d   = WLS_IDLE;
      end
      default: begin
        state_d = WLS_IDLE;
      end
    endcase

    // addr_q points at the next word to read; last_q keeps the last one issued.
    if (strobe) begin
      last_d = addr_q;
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      state_q  <= WLS_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      size_q   <= '0;
      word_q   <= '0;
      rounds_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      size_q   <= size_d;
      word_q   <= word_d;
      rounds_q <= rounds_d;
      round_q  <= round_d;
    end
  end

  assign bus.weight_addr_o  = strobe ? addr_q : last_q;
  assign bus.rd_weight_ld_o = strobe;
  assign bus.load_o         = loadPulse;
  assign bus.ready_o        = readyPulse;
  assign bus.done_o         = donePulse;
  assign bus.busy_o         = (state_q != WLS_IDLE);
  assign bus.round_o        = round_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Self-checking bench: per command, an expected event timeline is derived from the
// word/round rules and per-cycle ready/busy patterns, then compared cycle by cycle.
module tb_weight_load_sequencer;
  import sparhixcel_pkg::*;

  localparam int AW   = 16;
  localparam int NN   = 3;
  localparam int CW   = 3;
  localparam int RW   = 4;
  localparam int MAXC = 1024;

  logic clk_i = 1'b0;
  logic rd_weight_rst;

  weight_load_sequencer_if #(.ADDR_WIDTH(AW), .NUM_COL_WIDTH(CW), .ROUND_WIDTH(RW)) bus ();

  weight_load_sequencer #(.ADDR_WIDTH(AW), .N(NN), .NUM_COL_WIDTH(CW), .ROUND_WIDTH(RW)) dut (
    .clk_i         (clk_i),
    .rd_weight_rst (rd_weight_rst),
    .bus           (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  bit          readyArr [MAXC];
  bit          busyArr  [MAXC];
  bit          expLd    [MAXC];
  bit          expLoad  [MAXC];
  bit          expReady [MAXC];
  bit          expDone  [MAXC];
  logic [15:0] expAddr  [MAXC];
  int          expRound [MAXC];
  int          cmdEnd;
  logic [15:0] expLast;
  logic [15:0] lastAddr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic setDefaults();
    for (int c = 0; c < MAXC; c++) begin
      readyArr[c] = 1'b1;
      busyArr[c]  = 1'b0;
    end
  endtask

  task automatic randomPattern();
    setDefaults();
    for (int c = 0; c < 300; c++) begin
      readyArr[c] = ($urandom_range(0, 3) != 0);
      busyArr[c]  = ($urandom_range(0, 1) != 0);
    end
  endtask

  // Walks words and rounds, placing each strobe at the first cycle memory is ready.
  task automatic buildTimeline(input logic [15:0] base, input int size, input int rounds);
    int t;
    logic [15:0] a;
    for (int c = 0; c < MAXC; c++) begin
      expLd[c] = 0; expLoad[c] = 0; expReady[c] = 0; expDone[c] = 0;
      expAddr[c] = '0; expRound[c] = 0;
    end
    a = base;
    t = 1;
    cmdEnd = 1;
    for (int r = 0; r < rounds; r++) begin
      for (int w = 0; w < size; w++) begin
        while (!readyArr[t] && t < MAXC - 8) t++;
        expLd[t]   = 1;
        expAddr[t] = a;
        expLast    = a;
        a          = a + 16'd1;
        expLoad[t+1] = 1;
        if (w == size - 1) t = t + 2;
        else begin
`ifdef SPARHIXCEL_WLS_PREFETCH_EN
          t = readyArr[t+1] ? t + 1 : t + 2;
`else
          t = t + 2;
`endif
        end
      end
      expReady[t] = 1;
      for (int c = t + 1; c < MAXC; c++) expRound[c] = r + 1;
      if (r == rounds - 1) begin
        expDone[t+1] = 1;
        cmdEnd = t + 1;
      end else begin
        t = t + 1;
        while (busyArr[t] && t < MAXC - 8) t++;
        t = t + 1;
      end
    end
  endtask

  task automatic resetMidCommand();
    #2 rd_weight_rst = 1'b1;
    #1;
    checkOutput("rstStrobe", bus.rd_weight_ld_o, 0);
    checkOutput("rstLoad",   bus.load_o,         0);
    checkOutput("rstReady",  bus.ready_o,        0);
    checkOutput("rstDone",   bus.done_o,         0);
    checkOutput("rstBusy",   bus.busy_o,         0);
    checkOutput("rstRound",  bus.round_o,        0);
    checkOutput("rstAddr",   bus.weight_addr_o,  0);
    @(negedge clk_i);
    rd_weight_rst = 1'b0;
    lastAddr = '0;
    repeat (3) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checkOutput("postRstDone", bus.done_o, 0);
      checkOutput("postRstBusy", bus.busy_o, 0);
    end
  endtask

  // Start presented now; start is re-raised during DONE to confirm it is ignored.
  task automatic applyStimulus(input logic [15:0] base, input int size, input int rounds,
                               input int abortAt);
    bit aborted;
    aborted = 0;
    buildTimeline(base, size, rounds);
    bus.start_i        = 1'b1;
    bus.base_addr_i    = base;
    bus.filter_size_i  = CW'(size);
    bus.n_rounds_i     = RW'(rounds);
    bus.weight_ready_i = readyArr[0];
    bus.array_busy_i   = busyArr[0];
    for (int c = 1; c <= cmdEnd + 1 && !aborted; c++) begin
      @(posedge clk_i); #1;
      bus.start_i        = (c == cmdEnd);
      bus.weight_ready_i = readyArr[c];
      bus.array_busy_i   = busyArr[c];
      @(negedge clk_i);
      checkOutput("strobe", bus.rd_weight_ld_o, expLd[c]);
      checkOutput("load",   bus.load_o,         expLoad[c]);
      checkOutput("ready",  bus.ready_o,        expReady[c]);
      checkOutput("done",   bus.done_o,         expDone[c]);
      checkOutput("busy",   bus.busy_o,         (c <= cmdEnd));
      if (expLd[c]) checkOutput("addr", bus.weight_addr_o, expAddr[c]);
      if (c <= cmdEnd) checkOutput("round", bus.round_o, expRound[c]);
      else checkOutput("idleAddr", bus.weight_addr_o, expLast);
      if (c == abortAt) begin
        resetMidCommand();
        aborted = 1;
      end
    end
    bus.start_i = 1'b0;
    if (!aborted) lastAddr = expLast;
  endtask

  task automatic illegalStart(input int size, input int rounds);
    bus.start_i        = 1'b1;
    bus.base_addr_i    = 16'h0400;
    bus.filter_size_i  = CW'(size);
    bus.n_rounds_i     = RW'(rounds);
    bus.weight_ready_i = 1'b1;
    bus.array_busy_i   = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      @(negedge clk_i);
      checkOutput("illegalBusy",   bus.busy_o,         0);
      checkOutput("illegalStrobe", bus.rd_weight_ld_o, 0);
      checkOutput("illegalLoad",   bus.load_o,         0);
      checkOutput("illegalAddr",   bus.weight_addr_o,  lastAddr);
    end
  endtask

  initial begin
    int firstReady;
    rd_weight_rst      = 1'b1;
    bus.start_i        = 1'b0;
    bus.base_addr_i    = '0;
    bus.filter_size_i  = '0;
    bus.n_rounds_i     = '0;
    bus.weight_ready_i = 1'b0;
    bus.array_busy_i   = 1'b0;
    lastAddr           = '0;
    #12;
    checkOutput("resetStrobe", bus.rd_weight_ld_o, 0);
    checkOutput("resetLoad",   bus.load_o,         0);
    checkOutput("resetReady",  bus.ready_o,        0);
    checkOutput("resetDone",   bus.done_o,         0);
    checkOutput("resetBusy",   bus.busy_o,         0);
    checkOutput("resetRound",  bus.round_o,        0);
    checkOutput("resetAddr",   bus.weight_addr_o,  0);
    @(negedge clk_i);
    rd_weight_rst = 1'b0;

    setDefaults();
    applyStimulus(16'h0010, 3, 1, 0);

    setDefaults();
    buildTimeline(16'h0010, 2, 3);
    firstReady = 0;
    for (int c = MAXC - 1; c > 0; c--) if (expReady[c]) firstReady = c;
    for (int c = 1; c <= 4; c++) busyArr[firstReady + c] = 1'b1;
    applyStimulus(16'h0010, 2, 3, 0);

    setDefaults();
    for (int c = 3; c <= 5; c++) readyArr[c] = 1'b0;
    applyStimulus(16'h0010, 3, 1, 0);

    setDefaults();
    applyStimulus(16'hFFFF, 2, 1, 0);

    illegalStart(0, 1);
    illegalStart(4, 1);
    illegalStart(7, 2);
    illegalStart(2, 0);

    setDefaults();
    applyStimulus(16'h0010, 3, 1, 2);
    setDefaults();
    applyStimulus(16'h0010, 3, 1, 0);

    for (int k = 0; k < 20; k++) begin
      randomPattern();
      applyStimulus(16'($urandom), $urandom_range(1, 3), $urandom_range(1, 4), 0);
      if ($urandom_range(0, 3) == 0) illegalStart(0, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_load_sequencer.md
# weight_load_sequencer

Sequences weight loading into the systolic array for SparHiXcel. Per start command it fetches `filter_size` weight words per round from the weight memory, strobes the weight register, and pulses the array `load` once per word. It signals `ready` after each round and waits for the array to go idle between rounds. It sits between the SA controller (command/handshake) and the weight memory/register/array load path.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, weight memory address width
- `N`, 3, maximum filter size (words per round)
- `NUM_COL_WIDTH`, $clog2(N+1), width of `filter_size_i`
- `ROUND_WIDTH`, 4, width of round count

Ports:
- `clk_i`  in  1  clock
- `rd_weight_rst`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  command strobe, sampled in IDLE only
- `base_addr_i`  in  ADDR_WIDTH  first weight word address
- `filter_size_i`  in  NUM_COL_WIDTH  words per round; legal range 1..N
- `n_rounds_i`  in  ROUND_WIDTH  rounds per command; legal range 1..2^ROUND_WIDTH-1
- `weight_ready_i`  in  1  weight memory can accept a read
- `array_busy_i`  in  1  array computing; blocks the next round
- `weight_addr_o`  out  ADDR_WIDTH  current read address
- `rd_weight_ld_o`  out  1  read strobe to the weight memory and weight register
- `load_o`  out  1  array load pulse, one per word
- `ready_o`  out  1  one-cycle pulse when a round is fully loaded
- `busy_o`  out  1  high from the cycle after an accepted start through DONE
- `done_o`  out  1  one-cycle pulse at command end
- `round_o`  out  ROUND_WIDTH  rounds completed in the current command

## Operation
- States: IDLE, FETCH, LOAD, READY, WAIT, DONE.
- **IDLE**
  - On `start_i` with legal `filter_size_i` and `n_rounds_i`: latch size and rounds, set addr=`base_addr_i`, word=0, round=0, go to FETCH.
  - On an illegal start (size 0, size >N, or rounds 0): ignore it; stay in IDLE with no output activity.
- **FETCH**
  - If `weight_ready_i`=1: `rd_weight_ld_o`=1 with `weight_addr_o`=addr; then addr+1 and go to LOAD.
  - If `weight_ready_i`=0: stall with no strobe.
- **LOAD**
  - `load_o`=1; word+1.
  - If word reaches size: go to READY. Otherwise go to FETCH.
- **READY**
  - `ready_o`=1; round+1; word=0.
  - If round reaches rounds: go to DONE. Otherwise go to WAIT.
- **WAIT**: go to FETCH when `array_busy_i`=0.
- **DONE**: `done_o`=1; go to IDLE.
- Address continues contiguously across rounds; it is not reloaded per round.
- Address wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
- `start_i` outside IDLE is ignored, including `start_i` in the same cycle as DONE.
- `weight_addr_o` holds the last issued address while idle.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous and may occur mid-command; the command is abandoned with no `done_o`.
- Read latency: a strobe in cycle t means the word is on the array input in t+1, so `load_o` asserts in t+1.
- Baseline (start sampled at edge 0, size 3, 1 round, `weight_ready_i` always 1):
  - `rd_weight_ld_o` in cycles 1, 3, 5
  - `load_o` in cycles 2, 4, 6
  - `ready_o` in cycle 7
  - `done_o` in cycle 8
  - `busy_o` high in cycles 1..8
- Multi-round: after READY, WAIT lasts at least one cycle. With `array_busy_i`=0, the next round's first strobe is 2 cycles after `ready_o`.
- `rd_weight_ld_o` and `load_o` are mutually exclusive unless `SPARHIXCEL_WLS_PREFETCH_EN` is defined.

## Configuration
- Macro: `SPARHIXCEL_WLS_PREFETCH_EN`.
- Defined:
  - In LOAD, when more words remain and `weight_ready_i`=1, the next fetch is issued in the same cycle and the state stays in LOAD.
  - Throughput is 1 word/cycle. Size 3: strobes in cycles 1–3, loads in 2–4, `ready_o` in 5.
  - If `weight_ready_i`=0 during LOAD: load the current word, then go to FETCH.
- Undefined: 2 cycles per word, as described in Operation.

## Structure
- `sparhixcel_pkg` holds:
  - the state enum `wls_state_t`
  - default widths shared with SA_controller
- No sub-module. The block is one FSM plus address, word and round counters.

## Test plan
- Reset, then start with base=0x0010, size=3, rounds=1: strobes at addresses 0x10, 0x11, 0x12 in cycles 1/3/5; loads in 2/4/6; `ready_o` in 7; `done_o` in 8.
- Size=2, rounds=3, `array_busy_i` held 1 for 4 cycles after the first `ready_o`: exactly three `ready_o` pulses; addresses 0x10..0x15 contiguous; no strobe while busy; `round_o`=3 at `done_o`.
- `weight_ready_i` low for 3 cycles in FETCH of word 2: no strobe during the stall; the sequence resumes with the correct address; total `load_o` count is 3.
- Base=0xFFFF, size=2: addresses 0xFFFF then 0x0000.
- Start with size=0, then size=4 (N=3), then rounds=0: `busy_o` stays 0 and no strobes occur.
- Assert `rd_weight_rst` mid-LOAD: all outputs 0 immediately; no `done_o`; a new start then behaves per the first scenario. With `SPARHIXCEL_WLS_PREFETCH_EN` defined, the first scenario gives `ready_o` in cycle 5.
